// File: rtl/mixcolumn_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : mixcolumn_ctrl
//  Description : Column sequencer for a byte-serial MixColumns datapath.
//                Buffers one 4-byte column from a valid/ready stream, feeds it
//                to the datapath in four uninterrupted cycles, captures the
//                four result bytes and drains them on a valid/ready stream.
//                A per-column bypass passes the column through unmixed.
//  Revision    : 1.0 - initial release
// ============================================================================
module mixcolumn_ctrl #(
    parameter int NCOL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       bypass,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       done,
    output logic [7:0] mc_din,
    output logic [7:0] mc_en,
    input  logic [7:0] mc_dout0,
    input  logic [7:0] mc_dout1,
    input  logic [7:0] mc_dout2,
    input  logic [7:0] mc_dout3
);

    localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(NCOL - 1);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_FEED = 2'd2;
    localparam logic [1:0] ST_CAPT = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [1:0]      idx_q, idx_d;      // input fill index in LOAD, feed index k in FEED
    logic [3:0][7:0] ibuf_q, ibuf_d;    // ibuf[k] holds a_k
    logic            byp_q, byp_d;      // bypass flag captured with a0
    logic [3:0][7:0] obuf_q, obuf_d;    // obuf[k] holds b_k
    logic            ofull_q, ofull_d;  // output buffer holds an undrained column
    logic [1:0]      rd_q, rd_d;        // next output byte to drain
    logic [CW-1:0]   col_q, col_d;      // columns fully output so far (mod NCOL)
    logic            s_hs;
    logic            m_hs;

    // Stream handshakes and datapath drive, all decoded from registered state
    assign s_ready = (state_q == ST_LOAD) && !rst;
    assign s_hs    = s_valid && s_ready;
    assign m_valid = ofull_q;
    assign m_data  = ofull_q ? obuf_q[rd_q] : 8'h00;
    assign m_hs    = m_valid && m_ready;
    assign done    = m_hs && (rd_q == 2'd3) && (col_q == LAST_COL);
    assign mc_din  = (state_q == ST_FEED) ? ibuf_q[idx_q] : 8'h00;
    assign mc_en   = ((state_q == ST_FEED) && (idx_q != 2'd0)) ? 8'hFF : 8'h00;

    // Next-state logic: output drain runs independently of the input FSM;
    // the FSM only refills obuf once it is empty, so the two never collide
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ibuf_d  = ibuf_q;
        byp_d   = byp_q;
        obuf_d  = obuf_q;
        ofull_d = ofull_q;
        rd_d    = rd_q;
        col_d   = col_q;

        if (m_hs) begin
            rd_d = rd_q + 2'd1;
            if (rd_q == 2'd3) begin
                ofull_d = 1'b0;
                col_d   = (col_q == LAST_COL) ? '0 : col_q + CW'(1);
            end
        end

        case (state_q)
            ST_LOAD: begin
                if (s_hs) begin
                    ibuf_d[idx_q] = s_data;
                    if (idx_q == 2'd0) begin
                        byp_d = bypass;
                    end
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // The datapath cannot stall, so feeding starts only when the
                // result has somewhere to go
                if (!ofull_q) begin
                    if (byp_q) begin
                        obuf_d  = ibuf_q;
                        ofull_d = 1'b1;
                        rd_d    = 2'd0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_FEED;
                    end
                end
            end
            ST_FEED: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = ST_CAPT;
                end
            end
            default: begin
                obuf_d  = {mc_dout3, mc_dout2, mc_dout1, mc_dout0};
                ofull_d = 1'b1;
                rd_d    = 2'd0;
                state_d = ST_LOAD;
            end
        endcase
    end

    // State registers with synchronous reset; partial columns are discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            idx_q   <= 2'd0;
            ibuf_q  <= '0;
            byp_q   <= 1'b0;
            obuf_q  <= '0;
            ofull_q <= 1'b0;
            rd_q    <= 2'd0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ibuf_q  <= ibuf_d;
            byp_q   <= byp_d;
            obuf_q  <= obuf_d;
            ofull_q <= ofull_d;
            rd_q    <= rd_d;
            col_q   <= col_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mixcolumn_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mixcolumn_ctrl
//  Description : Directed self-checking bench for mixcolumn_ctrl with a
//                behavioural byte-serial MixColumns datapath attached.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mixcolumn_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       bypass = 1'b0;
    logic       m_ready = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       done;
    logic [7:0] mc_din;
    logic [7:0] mc_en;
    logic [7:0] dp [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [1:0] kk = 2'd0;

    int cyc = 0;
    int n_vec = 0;
    int n_miss = 0;
    int mode = 0;             // 0: m_ready=1, 1: random, 2: m_ready=0
    logic [7:0] got[$];
    int         got_cyc[$];
    logic [7:0] exp_q[$];
    int done_cnt = 0;
    int done_idx = -1;
    int done_spur = 0;
    int en_err = 0;
    int ffrun = 0;
    bit en_mon = 1'b1;

    mixcolumn_ctrl #(.NCOL(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .bypass   (bypass),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .done     (done),
        .mc_din   (mc_din),
        .mc_en    (mc_en),
        .mc_dout0 (dp[0]),
        .mc_dout1 (dp[1]),
        .mc_dout2 (dp[2]),
        .mc_dout3 (dp[3])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input int c, input logic [7:0] x);
        logic [7:0] xt;
        xt = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        case (c)
            2:       return xt;
            3:       return xt ^ x;
            default: return x;
        endcase
    endfunction

    // Coefficient of a_k in row i of the MixColumns matrix
    function automatic int coef(input int i, input int k);
        case ((k - i) & 3)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    // Byte-serial datapath: en=00 loads the first product, en=FF accumulates
    always @(posedge clk) begin
        if (mc_en == 8'h00) begin
            for (int i = 0; i < 4; i++) dp[i] <= gmul(coef(i, 0), mc_din);
            kk <= 2'd1;
        end else begin
            for (int i = 0; i < 4; i++) dp[i] <= dp[i] ^ gmul(coef(i, int'(kk)), mc_din);
            kk <= kk + 2'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
        end
    endtask

    // m_ready driver plus output and mc_en monitors, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
            #1;
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                got_cyc.push_back(cyc);
                if (done) begin
                    done_cnt++;
                    done_idx = got.size() - 1;
                end
            end else if (done) begin
                done_spur++;
            end
            if (en_mon) begin
                if (mc_en == 8'hFF) ffrun++;
                else if (mc_en == 8'h00) begin
                    if (ffrun != 0 && ffrun != 3) en_err++;
                    ffrun = 0;
                end else en_err++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_s_ready_low", {31'd0, s_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_s_ready_high", {31'd0, s_ready}, 32'd1);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_mc_din", {24'd0, mc_din}, 32'd0);
        check("rst_mc_en", {24'd0, mc_en}, 32'd0);
        got.delete();
        got_cyc.delete();
        exp_q.delete();
        done_cnt = 0;
        done_idx = -1;
        done_spur = 0;
    endtask

    // Sends a0..a3 (MSB first); n returns the cycle of the 4th handshake
    task automatic send_col(input logic [31:0] col, input logic byp, output int n);
        n = -1;
        for (int i = 0; i < 4; i++) begin
            int t;
            t = 0;
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = col[31 - 8*i -: 8];
            bypass  = byp;
            #1;
            while (!s_ready && t < 200) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (!s_ready) check("s_ready_timeout", {31'd0, s_ready}, 32'd1);
            n = cyc;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 8'h00;
        bypass  = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] col);
        for (int i = 0; i < 4; i++) exp_q.push_back(col[31 - 8*i -: 8]);
    endtask

    task automatic wait_bytes(input int k);
        int t;
        t = 0;
        while (got.size() < k && t < 2000) begin
            @(negedge clk);
            t++;
        end
        #2;
        if (got.size() < k) check("drain_timeout", got.size(), k);
    endtask

    task automatic compare_stream(input string tag);
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i),
                  (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
        check({tag, "_count"}, got.size(), exp_q.size());
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_idx"}, done_idx, 15);
        check({tag, "_done_spur"}, done_spur, 0);
    endtask

    initial begin
        int n;
        do_reset();

        // Single mixed and fixed-point columns, one at a time
        mode = 0;
        send_col(32'hd4bf5d30, 1'b0, n);
        push_exp(32'h046681e5);
        wait_bytes(4);
        check("latency_mix", (got_cyc.size() > 0) ? got_cyc[0] - n : -1, 7);
        send_col(32'hdb135345, 1'b0, n);
        push_exp(32'h8e4da1bc);
        wait_bytes(8);
        send_col(32'h01010101, 1'b0, n);
        push_exp(32'h01010101);
        wait_bytes(12);
        send_col(32'hc6c6c6c6, 1'b0, n);
        push_exp(32'hc6c6c6c6);
        wait_bytes(16);
        compare_stream("single");
        check_done("single");

        // Full state streamed with random backpressure
        do_reset();
        mode = 1;
        send_col(32'hd4bf5d30, 1'b0, n);
        send_col(32'hdb135345, 1'b0, n);
        send_col(32'h01010101, 1'b0, n);
        send_col(32'hc6c6c6c6, 1'b0, n);
        push_exp(32'h046681e5);
        push_exp(32'h8e4da1bc);
        push_exp(32'h01010101);
        push_exp(32'hc6c6c6c6);
        wait_bytes(16);
        compare_stream("state");
        check_done("state");

        // Bypass on column 2 only
        do_reset();
        mode = 0;
        send_col(32'h01010101, 1'b0, n);
        wait_bytes(4);
        send_col(32'hc6c6c6c6, 1'b0, n);
        wait_bytes(8);
        send_col(32'hd4bf5d30, 1'b1, n);
        wait_bytes(12);
        check("latency_bypass", (got_cyc.size() > 8) ? got_cyc[8] - n : -1, 2);
        send_col(32'hdb135345, 1'b0, n);
        wait_bytes(16);
        push_exp(32'h01010101);
        push_exp(32'hc6c6c6c6);
        push_exp(32'hd4bf5d30);
        push_exp(32'h8e4da1bc);
        compare_stream("bypass");
        check_done("bypass");

        // Downstream stall: first result held, second column parks in WAIT
        do_reset();
        mode = 2;
        send_col(32'hd4bf5d30, 1'b0, n);
        send_col(32'hdb135345, 1'b0, n);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("stall_m_valid", {31'd0, m_valid}, 32'd1);
            check("stall_m_data", {24'd0, m_data}, 32'h04);
            check("stall_s_ready", {31'd0, s_ready}, 32'd0);
            check("stall_mc_en", {24'd0, mc_en}, 32'd0);
        end
        mode = 0;
        push_exp(32'h046681e5);
        push_exp(32'h8e4da1bc);
        wait_bytes(8);
        compare_stream("stall");
        check("mc_en_sequence", en_err, 0);

        // Reset in the middle of FEED (k=2), then a fresh column
        do_reset();
        en_mon = 1'b0;
        mode = 0;
        send_col(32'hd4bf5d30, 1'b0, n);
        repeat (3) @(negedge clk);
        #1;
        check("feed_k2_mc_en", {24'd0, mc_en}, 32'hFF);
        check("feed_k2_mc_din", {24'd0, mc_din}, 32'h5d);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        check("midrst_m_data", {24'd0, m_data}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_mc_din", {24'd0, mc_din}, 32'd0);
        check("midrst_mc_en", {24'd0, mc_en}, 32'd0);
        check("midrst_s_ready", {31'd0, s_ready}, 32'd1);
        send_col(32'hdb135345, 1'b0, n);
        push_exp(32'h8e4da1bc);
        wait_bytes(4);
        compare_stream("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d bytes", got.size());
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
